// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand bypass selection and load-use stall detection.
// A DEPTH-entry shadow pipeline mirrors the in-flight register writes after ID.
// Each source operand independently picks the nearest producing stage; a
// nearest producer that is a load still inside its latency window stalls ID.
//
// Hold protocol: stall=1 means IF/ID must keep the current instruction for
// this cycle and a bubble is inserted into stage 1. The instruction is
// accepted into stage 1 only on a cycle with issue_valid=1, stall=0 and
// flush=0. flush always wins over stall.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_LAT   = 1,
  parameter int R0_ZERO    = 0,
  parameter int CNT_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  issue_valid,
  input  logic [REG_ADDR_W-1:0]                 issue_rd,
  input  logic                                  issue_regwrite,
  input  logic                                  issue_is_load,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]         id_src,
  input  logic [NUM_SRC-1:0]                    id_src_used,
  input  logic                                  flush,
  output logic                                  stall,
  output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]    fwd_sel,
  output logic [CNT_W-1:0]                      stall_count
);

  localparam int SELW = $clog2(DEPTH + 1);

  // Shadow pipeline: index k-1 holds stage k (index 0 = nearest stage).
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [DEPTH-1:0]      rw_q, rw_d;
  logic [DEPTH-1:0]      ld_q, ld_d;
  logic [REG_ADDR_W-1:0] rd_q [DEPTH];
  logic [REG_ADDR_W-1:0] rd_d [DEPTH];

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_SRC-1:0]        hit;
  logic [NUM_SRC-1:0]        req;
  logic [NUM_SRC*SELW-1:0]   sel_raw;
  logic                      accept;

  // Per-operand nearest-producer search; an unavailable load blocks older stages.
  always_comb begin
    hit     = '0;
    req     = '0;
    sel_raw = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!hit[i] && vld_q[k] && rw_q[k] && id_src_used[i] &&
            (rd_q[k] == id_src[i*REG_ADDR_W +: REG_ADDR_W]) &&
            !((R0_ZERO != 0) && (id_src[i*REG_ADDR_W +: REG_ADDR_W] == '0))) begin
          hit[i] = 1'b1;
          if (ld_q[k] && ((k + 1) <= LOAD_LAT)) begin
            req[i] = 1'b1;
          end else begin
            sel_raw[i*SELW +: SELW] = SELW'(k + 1);
          end
        end
      end
    end
  end

  assign stall   = ~rst & issue_valid & ~flush & (|req);
  assign fwd_sel = rst ? '0 : sel_raw;
  assign accept  = issue_valid & ~stall & ~flush;

  // Next shadow-pipeline contents: accepted instruction or bubble enters stage 1.
  always_comb begin
    vld_d    = '0;
    rw_d     = '0;
    ld_d     = '0;
    for (int k = 0; k < DEPTH; k++) rd_d[k] = '0;
    vld_d[0] = accept;
    rw_d[0]  = accept & issue_regwrite;
    ld_d[0]  = accept & issue_is_load;
    rd_d[0]  = accept ? issue_rd : '0;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      rw_d[k]  = rw_q[k-1];
      ld_d[k]  = ld_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers with synchronous reset clearing all in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      rw_q  <= '0;
      ld_q  <= '0;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      rw_q  <= rw_d;
      ld_q  <= ld_d;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= rd_d[k];
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Testbench for hazard_forward_unit: two instances (short pipe with 16-bit
// counter, deep pipe with 2-bit counter) share one ID stimulus stream. A
// list-of-in-flight-instructions reference model predicts each cycle's
// outputs into a queue that a negedge monitor pops and compares.
module tb_hazard_forward_unit;

  localparam int DA = 2, LA = 1, CA = 16, SA = 2;
  localparam int DB = 6, LB = 5, CB = 2,  SB = 3;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv, rw, ld, fl;
  logic [2:0] rd;
  logic [5:0] src;
  logic [1:0] used;

  logic          stall_a, stall_b;
  logic [3:0]    sel_a;
  logic [5:0]    sel_b;
  logic [CA-1:0] cnt_a;
  logic [CB-1:0] cnt_b;

  hazard_forward_unit #(.REG_ADDR_W(3), .NUM_SRC(2), .DEPTH(DA), .LOAD_LAT(LA),
                        .R0_ZERO(1), .CNT_W(CA)) u_a (
    .clk(clk), .rst(rst), .issue_valid(iv), .issue_rd(rd), .issue_regwrite(rw),
    .issue_is_load(ld), .id_src(src), .id_src_used(used), .flush(fl),
    .stall(stall_a), .fwd_sel(sel_a), .stall_count(cnt_a));

  hazard_forward_unit #(.REG_ADDR_W(3), .NUM_SRC(2), .DEPTH(DB), .LOAD_LAT(LB),
                        .R0_ZERO(1), .CNT_W(CB)) u_b (
    .clk(clk), .rst(rst), .issue_valid(iv), .issue_rd(rd), .issue_regwrite(rw),
    .issue_is_load(ld), .id_src(src), .id_src_used(used), .flush(fl),
    .stall(stall_b), .fwd_sel(sel_b), .stall_count(cnt_b));

  // Reference model: list of in-flight instructions per instance, [0] = nearest.
  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       rw;
    logic       ld;
  } ent_t;

  ent_t p [2][8];
  int   cnt_m [2];
  int   depth_m [2];
  int   ll_m [2];
  int   cmax_m [2];

  logic [29:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Outputs predicted from the in-flight list and the current ID inputs.
  task automatic model_eval(input int u, output logic st, output int s0, output int s1);
    int   s [2];
    logic rq [2];
    logic [2:0] sv;
    logic any;
    any = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s[i]  = 0;
      rq[i] = 1'b0;
      sv    = src[i*3 +: 3];
      // walk oldest to nearest so the nearest producer is the last word
      for (int k = depth_m[u]; k >= 1; k--) begin
        if (p[u][k-1].v && p[u][k-1].rw && used[i] && p[u][k-1].rd == sv && sv != 3'd0) begin
          if (p[u][k-1].ld && k <= ll_m[u]) begin
            rq[i] = 1'b1;
            s[i]  = 0;
          end else begin
            rq[i] = 1'b0;
            s[i]  = k;
          end
        end
      end
      any = any | rq[i];
    end
    st = any & iv & ~fl & ~rst;
    s0 = rst ? 0 : s[0];
    s1 = rst ? 0 : s[1];
  endtask

  // Model update at the clock edge.
  task automatic model_advance(input int u, input logic st);
    if (rst) begin
      for (int k = 0; k < 8; k++) p[u][k] = '0;
      cnt_m[u] = 0;
    end else begin
      for (int k = depth_m[u] - 1; k >= 1; k--) p[u][k] = p[u][k-1];
      p[u][0] = (iv && !st && !fl) ? {1'b1, rd, rw, ld} : '0;
      if (st && cnt_m[u] < cmax_m[u]) cnt_m[u] = cnt_m[u] + 1;
    end
  endtask

  // Driver: apply one cycle of ID inputs, push prediction, advance model.
  task automatic step(input logic iv_, input logic [2:0] rd_, input logic rw_, input logic ld_,
                      input logic [5:0] src_, input logic [1:0] used_, input logic fl_,
                      input logic rs_);
    logic sta, stb;
    int a0, a1, b0, b1;
    iv = iv_; rd = rd_; rw = rw_; ld = ld_; src = src_; used = used_; fl = fl_; rst = rs_;
    model_eval(0, sta, a0, a1);
    model_eval(1, stb, b0, b1);
    exp_q.push_back({sta, 2'(a1), 2'(a0), 16'(cnt_m[0]), stb, 3'(b1), 3'(b0), 2'(cnt_m[1])});
    @(posedge clk);
    model_advance(0, sta);
    model_advance(1, stb);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: compares DUT outputs mid-cycle against the queue head.
  initial begin
    logic [29:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_stall", 32'(stall_a), 32'(e[29]));
        chk("a_fwd_sel", 32'(sel_a), 32'(e[28:25]));
        chk("a_stall_count", 32'(cnt_a), 32'(e[24:9]));
        chk("b_stall", 32'(stall_b), 32'(e[8]));
        chk("b_fwd_sel", 32'(sel_b), 32'(e[7:2]));
        chk("b_stall_count", 32'(cnt_b), 32'(e[1:0]));
      end
    end
  end

  initial begin
    depth_m[0] = DA; ll_m[0] = LA; cmax_m[0] = (1 << CA) - 1;
    depth_m[1] = DB; ll_m[1] = LB; cmax_m[1] = (1 << CB) - 1;
    iv = 0; rd = 0; rw = 0; ld = 0; src = 0; used = 0; fl = 0; rst = 1;
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 8; k++) p[u][k] = '0;
      cnt_m[u] = 0;
    end
    // reset state, inputs held active
    step(1, 3'd1, 1, 0, {3'd1, 3'd1}, 2'b11, 0, 1);
    step(0, 3'd0, 0, 0, 6'd0, 2'b00, 0, 0);

    // ALU chain
    step(1, 3'd3, 1, 0, 6'd0, 2'b00, 0, 0);
    step(1, 3'd0, 0, 0, {3'd0, 3'd3}, 2'b01, 0, 0);
    step(0, 3'd0, 0, 0, {3'd0, 3'd3}, 2'b01, 0, 0);
    step(0, 3'd0, 0, 0, {3'd0, 3'd3}, 2'b01, 0, 0);

    // priority: both stages write r5, then r2/r6 split
    step(1, 3'd5, 1, 0, 6'd0, 2'b00, 0, 0);
    step(1, 3'd5, 1, 0, 6'd0, 2'b00, 0, 0);
    step(0, 3'd0, 0, 0, {3'd5, 3'd5}, 2'b11, 0, 0);
    step(1, 3'd2, 1, 0, 6'd0, 2'b00, 0, 0);
    step(1, 3'd6, 1, 0, 6'd0, 2'b00, 0, 0);
    step(0, 3'd0, 0, 0, {3'd2, 3'd6}, 2'b11, 0, 0);

    // load-use: dependent held through its stall
    step(1, 3'd4, 1, 1, 6'd0, 2'b00, 0, 0);
    step(1, 3'd1, 1, 0, {3'd0, 3'd4}, 2'b01, 0, 0);
    step(1, 3'd1, 1, 0, {3'd0, 3'd4}, 2'b01, 0, 0);
    step(0, 3'd0, 0, 0, 6'd0, 2'b00, 0, 0);

    // gating: unused operand, hardwired r0
    step(1, 3'd4, 1, 0, 6'd0, 2'b00, 0, 0);
    step(0, 3'd0, 0, 0, {3'd4, 3'd4}, 2'b10, 0, 0);
    step(1, 3'd0, 1, 0, 6'd0, 2'b00, 0, 0);
    step(0, 3'd0, 0, 0, {3'd0, 3'd0}, 2'b11, 0, 0);

    // flush during load-use
    step(1, 3'd4, 1, 1, 6'd0, 2'b00, 0, 0);
    step(1, 3'd2, 1, 0, {3'd0, 3'd4}, 2'b01, 1, 0);
    step(0, 3'd0, 0, 0, {3'd0, 3'd2}, 2'b01, 0, 0);

    // reset with two valid entries in flight
    step(1, 3'd6, 1, 0, 6'd0, 2'b00, 0, 0);
    step(1, 3'd7, 1, 1, 6'd0, 2'b00, 0, 0);
    step(1, 3'd1, 1, 0, {3'd6, 3'd7}, 2'b11, 0, 1);
    step(0, 3'd0, 0, 0, {3'd6, 3'd7}, 2'b11, 0, 0);

    // long load-use on the deep instance saturates its 2-bit counter
    step(1, 3'd7, 1, 1, 6'd0, 2'b00, 0, 0);
    for (int n = 0; n < 7; n++) step(1, 3'd0, 0, 0, {3'd0, 3'd7}, 2'b01, 0, 0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))},
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 59) == 0));
    end

    // drain with a bounded wait
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
